// File: rtl/beat_pattern_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | beat_pattern_gen: steps a value through [start,end] at a programmable tick  |
// | rate in up-wrap, down-wrap, ping-pong or one-shot order.                    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module beat_pattern_gen #(
  parameter int WIDTH     = 8,
  parameter int DIV_W     = 16,
  parameter int START_DEF = 160,
  parameter int END_DEF   = 176,
  parameter int STEP_DEF  = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] cfg_start,
  input  logic [WIDTH-1:0] cfg_end,
  input  logic [WIDTH-1:0] cfg_step,
  input  logic [1:0]       cfg_mode,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_load,
  input  logic             run,
  output logic [WIDTH-1:0] data,
  output logic             data_en,
  output logic             wrap,
  output logic             done,
  output logic             cfg_err
);

  localparam logic [1:0] c_mode_up      = 2'd0;
  localparam logic [1:0] c_mode_down    = 2'd1;
  localparam logic [1:0] c_mode_ping    = 2'd2;
  localparam logic [1:0] c_mode_oneshot = 2'd3;

  logic [WIDTH-1:0] r_start, r_end, r_step, r_data;
  logic [1:0]       r_mode;
  logic [DIV_W-1:0] r_div, r_cnt;
  logic             r_dir_dn, r_data_en, r_wrap, r_done, r_cfg_err;

  logic [WIDTH:0]   w_sum, w_lo;
  logic [WIDTH-1:0] w_inc, w_dec;
  logic             w_over, w_under, w_active, w_tick;

  // One extra bit keeps range compares free of overflow aliasing.
  assign w_sum    = {1'b0, r_data} + {1'b0, r_step};
  assign w_lo     = {1'b0, r_start} + {1'b0, r_step};
  assign w_over   = w_sum > {1'b0, r_end};
  assign w_under  = {1'b0, r_data} < w_lo;
  assign w_inc    = w_sum[WIDTH-1:0];
  assign w_dec    = r_data - r_step;
  assign w_active = run && !r_done && !r_cfg_err;
  assign w_tick   = w_active && (r_cnt == r_div);

  assign data    = r_data;
  assign data_en = r_data_en;
  assign wrap    = r_wrap;
  assign done    = r_done;
  assign cfg_err = r_cfg_err;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_start   <= WIDTH'(START_DEF);
      r_end     <= WIDTH'(END_DEF);
      r_step    <= WIDTH'(STEP_DEF);
      r_mode    <= c_mode_up;
      r_div     <= '0;
      r_cnt     <= '0;
      r_data    <= WIDTH'(START_DEF);
      r_dir_dn  <= 1'b0;
      r_data_en <= 1'b0;
      r_wrap    <= 1'b0;
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
    end else if (cfg_load) begin
      r_start   <= cfg_start;
      r_end     <= cfg_end;
      r_step    <= cfg_step;
      r_mode    <= cfg_mode;
      r_div     <= cfg_div;
      r_cnt     <= '0;
      r_data    <= (cfg_mode == c_mode_down) ? cfg_end : cfg_start;
      r_dir_dn  <= 1'b0;
      r_data_en <= 1'b0;
      r_wrap    <= 1'b0;
      r_done    <= 1'b0;
      r_cfg_err <= cfg_start > cfg_end;
    end else begin
      r_data_en <= 1'b0;
      r_wrap    <= 1'b0;
      if (w_active) begin
        r_cnt <= w_tick ? '0 : r_cnt + DIV_W'(1);
      end
      if (w_tick) begin
        case (r_mode)
          c_mode_up: begin
            r_data_en <= 1'b1;
            if (w_over) begin
              r_data <= r_start;
              r_wrap <= 1'b1;
            end else begin
              r_data <= w_inc;
            end
          end
          c_mode_down: begin
            r_data_en <= 1'b1;
            if (w_under) begin
              r_data <= r_end;
              r_wrap <= 1'b1;
            end else begin
              r_data <= w_dec;
            end
          end
          c_mode_ping: begin
            r_data_en <= 1'b1;
            if (!r_dir_dn) begin
              if (w_over) begin
                r_dir_dn <= 1'b1;
                r_data   <= w_under ? r_start : w_dec;
                r_wrap   <= 1'b1;
              end else begin
                r_data <= w_inc;
              end
            end else begin
              if (w_under) begin
                r_dir_dn <= 1'b0;
                r_data   <= w_over ? r_end : w_inc;
                r_wrap   <= 1'b1;
              end else begin
                r_data <= w_dec;
              end
            end
          end
          c_mode_oneshot: begin
            // Reaching the end freezes the value without a final beat.
            if (w_over) begin
              r_done <= 1'b1;
            end else begin
              r_data    <= w_inc;
              r_data_en <= 1'b1;
            end
          end
          default: r_data_en <= 1'b0;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
